// File: rtl/key_char_fifo.sv
// ---------------------------------------------------------------------------
// key_char_fifo
//
// Purpose: turns PS/2 make events into 5-bit character codes
// (a-z -> 1..26, space -> 27, optional backspace -> 31) and queues them in a
// small FIFO. The counting stage drains the FIFO with a valid/ready
// handshake. Enter presses are reported as a one-cycle pulse and are never
// queued.
//
// Optional feature macro: KEYFIFO_BACKSPACE_EN
//   defined   -> backspace (scan code 66) is queued as code 31
//   undefined -> backspace is dropped like any unmapped key
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   key_valid       one-cycle pulse per decoder make/break event
//   last_change     scan code of that event, bit 8 = E0 extended flag
//   key_down        held-key bitmap indexed by scan code
//   enable          accept new characters only while high
//   flush           synchronous clear of FIFO, overflow flag and counter
//   char_ready      consumer ready
//   char_valid      FIFO not empty
//   char_code       head-of-FIFO code (holds last value while empty)
//   enter_pulse     one-cycle pulse after an Enter press
//   overflow        sticky: a code was dropped on a full FIFO
//   char_cnt        saturating count of codes written into the FIFO
// ---------------------------------------------------------------------------
module key_char_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [8:0]       last_change,
  input  logic [127:0]     key_down,
  input  logic             enable,
  input  logic             flush,
  input  logic             char_ready,
  output logic             char_valid,
  output logic [4:0]       char_code,
  output logic             enter_pulse,
  output logic             overflow,
  output logic [CNT_W-1:0] char_cnt
);

  localparam int AW = $clog2(DEPTH);

  // Set-2 scan code to character code; 0 means "not a queued character".
  function automatic logic [4:0] map_code(input logic [6:0] sc);
    logic [4:0] code;
    code = 5'd0;
    case (sc)
      7'h1C: code = 5'd1;   7'h32: code = 5'd2;   7'h21: code = 5'd3;
      7'h23: code = 5'd4;   7'h24: code = 5'd5;   7'h2B: code = 5'd6;
      7'h34: code = 5'd7;   7'h33: code = 5'd8;   7'h43: code = 5'd9;
      7'h3B: code = 5'd10;  7'h42: code = 5'd11;  7'h4B: code = 5'd12;
      7'h3A: code = 5'd13;  7'h31: code = 5'd14;  7'h44: code = 5'd15;
      7'h4D: code = 5'd16;  7'h15: code = 5'd17;  7'h2D: code = 5'd18;
      7'h1B: code = 5'd19;  7'h2C: code = 5'd20;  7'h3C: code = 5'd21;
      7'h2A: code = 5'd22;  7'h1D: code = 5'd23;  7'h22: code = 5'd24;
      7'h35: code = 5'd25;  7'h1A: code = 5'd26;
      7'h29: code = 5'd27;
`ifdef KEYFIFO_BACKSPACE_EN
      7'h66: code = 5'd31;
`endif
      default: code = 5'd0;
    endcase
    return code;
  endfunction

  logic             r_dec_valid;
  logic [4:0]       r_dec_code;
  logic             r_enter;
  logic             r_overflow;
  logic [CNT_W-1:0] r_cnt;
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [4:0]       r_last;
  logic [4:0]       r_mem [DEPTH];

  logic       w_press;
  logic [4:0] w_map;
  logic       w_load;
  logic       w_is_enter;
  logic       w_empty;
  logic       w_full;
  logic       w_pop;
  logic       w_write;
  logic       w_drop;
  logic [4:0] w_head;

  // Extended codes and codes >= 0x80 are rejected by bits [8:7]; break
  // events are rejected because the key is no longer held.
  assign w_press    = key_valid && (last_change[8:7] == 2'b00) && key_down[last_change[6:0]];
  assign w_map      = map_code(last_change[6:0]);
  assign w_load     = w_press && enable && (w_map != 5'd0);
  assign w_is_enter = w_press && (last_change[6:0] == 7'h5A);

  // Pointers carry one extra wrap bit: equal -> empty, only wrap bit
  // differing -> full.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && char_ready;
  // A pop in the same cycle frees the slot the write needs.
  assign w_write = r_dec_valid && (!w_full || w_pop);
  assign w_drop  = r_dec_valid && w_full && !w_pop;

  assign w_head = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dec_valid <= 1'b0;
      r_dec_code  <= 5'd0;
      r_enter     <= 1'b0;
      r_overflow  <= 1'b0;
      r_cnt       <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_last      <= 5'd0;
    end else begin
      // Enter is reported regardless of enable and flush.
      r_enter <= w_is_enter;
      if (!w_empty) begin
        r_last <= w_head;
      end
      if (flush) begin
        r_dec_valid <= 1'b0;
        r_dec_code  <= 5'd0;
        r_overflow  <= 1'b0;
        r_cnt       <= '0;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
      end else begin
        r_dec_valid <= w_load;
        r_dec_code  <= w_map;
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
        if (w_write) begin
          r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
          if (r_cnt != {CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  // Storage has no reset: its contents are only visible while non-empty.
  always_ff @(posedge clk) begin
    if (!flush && w_write) begin
      r_mem[r_wr_ptr[AW-1:0]] <= r_dec_code;
    end
  end

  assign char_valid  = !w_empty;
  assign char_code   = w_empty ? r_last : w_head;
  assign enter_pulse = r_enter;
  assign overflow    = r_overflow;
  assign char_cnt    = r_cnt;

endmodule

// File: doc/key_char_fifo.md
# key_char_fifo

Upstream input stage of the TypeRacer datapath. It takes raw PS/2 key events from the keyboard decoder and turns presses into 5-bit character codes. Codes go into a 4-entry FIFO that the scoring/counting stage pops with a valid/ready handshake. It also reports Enter presses, FIFO overflow and a running count of accepted characters.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- CNT_W, 10, width of the accepted-character counter.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous, active-high reset.
- key_valid, in, 1, one-cycle pulse when the decoder reports a make or break event.
- last_change, in, 9, scan code of that event; bit 8 is the E0 extended flag.
- key_down, in, 128, current held-key bitmap indexed by the scan code.
- enable, in, 1, accept characters only while high (game in typing state).
- flush, in, 1, synchronous clear of the FIFO, overflow flag and counter.
- char_ready, in, 1, consumer ready.
- char_valid, out, 1, FIFO not empty.
- char_code, out, 5, head-of-FIFO code.
- enter_pulse, out, 1, one-cycle pulse on an Enter press (accepted regardless of enable).
- overflow, out, 1, sticky: a character was dropped because the FIFO was full.
- char_cnt, out, CNT_W, saturating count of characters written into the FIFO.

## Operation
- **Press detect:** an event is a press when key_valid=1, last_change[8:7]=0, and key_down[last_change[6:0]]=1. Break events, extended codes and codes ≥ 0x80 are ignored.
- **Code map (set 2):**
  - a–z → 1–26. Scan codes: A 1C, B 32, C 21, D 23, E 24, F 2B, G 34, H 33, I 43, J 3B, K 42, L 4B, M 3A, N 31, O 44, P 4D, Q 15, R 2D, S 1B, T 2C, U 3C, V 2A, W 1D, X 22, Y 35, Z 1A.
  - space 29 → 27.
  - backspace 66 → 31 (see Configuration).
  - Enter 5A → enter_pulse only; it is never enqueued.
  - All other codes are dropped silently.
  - Code 0 is never produced.
- **Stage 1:** a registered decode holds {dec_valid, dec_code}. dec_valid is set only when the press is mapped and enable=1 at the key_valid cycle.
- **Stage 2:** the FIFO write.
  - Write when dec_valid=1.
  - Pop when char_valid && char_ready.
  - Full and pop in the same cycle: both occur; nothing is dropped, count stays DEPTH.
  - Full and no pop: the new code is dropped and overflow is set.
  - Empty: char_code holds its last value; consumers must not sample it.
  - Read and write pointers are log2(DEPTH)+1 bits; full/empty come from the MSB compare and wrap naturally.
- **char_cnt:** increments on every successful FIFO write and saturates at 2^CNT_W−1.
- **flush:**
  - Has priority over push and pop.
  - Pointers, overflow and char_cnt go to 0. The stage-1 register is cleared in the same edge, so an in-flight press is discarded.
  - enter_pulse is unaffected.
- **enable low:** prevents new stage-1 loads only. Codes already in the FIFO remain poppable.

## Timing
- **Reset values:** char_valid 0, char_code 0, enter_pulse 0, overflow 0, char_cnt 0, pointers 0, stage-1 register 0. Reset takes effect immediately (asynchronous).
- **Character latency:** key_valid sampled at edge N → dec_valid after N → FIFO write at edge N+1 → char_valid=1 after edge N+1 (2 cycles).
- **enter_pulse:** registered; high for exactly the one cycle after edge N.
- **Pop:** takes effect at the edge where char_valid && char_ready; the next entry, or char_valid=0, is visible after that edge.
- **Back-to-back input:** key_valid on consecutive cycles is accepted at full rate, one code per cycle.
- **Reset mid-operation:** all queued codes are lost; no pulse is emitted.

## Configuration
- **KEYFIFO_BACKSPACE_EN**
  - Defined: backspace (66) is enqueued as code 31 and counted in char_cnt.
  - Undefined: backspace is treated as an unmapped code and dropped; code 31 never appears.

## Test plan
- Reset, then press A (key_valid, last_change=0x01C, key_down[0x1C]=1) with enable=1 and char_ready=0 → char_valid rises 2 cycles later, char_code=1, char_cnt=1.
- Press Q, W, E, R, T on consecutive cycles with char_ready=0 → FIFO holds 17, 23, 5, 18; T is dropped, overflow=1, char_cnt=4. Then char_ready=1 → pops 17, 23, 5, 18 on successive cycles, then char_valid=0.
- FIFO full, with char_ready=1 and a space press arriving at the write edge → pop and push occur together; the tail entry is 27 and overflow stays 0.
- Break event for A (key_down[0x1C]=0), extended code 0x11C, and an unmapped code 0x05 → no writes. Enter (0x05A) with enable=0 → enter_pulse high for one cycle and no write.
- Backspace (0x066) press → with KEYFIFO_BACKSPACE_EN defined, code 31 is enqueued; without it, no write.
- Three entries queued and flush asserted in the same cycle as a new press → char_valid=0, overflow=0, char_cnt=0 next cycle, and the pending press never appears. Separately, rst asserted mid-pop → all outputs return to 0 immediately.
